branch_resolve_bht: RTL and testbench

Parametrised successor to the ID-stage branch resolver. It resolves BEQ/BNE/BLEZ/BGTZ/J/JAL and registers the redirect one cycle later. It holds a branch history table (BHT) of 2-bit saturating counters that the IF stage reads for direction prediction, plus saturating branch and mispredict statistics counters. It sits between IF (prediction lookup) and ID (resolution), and drives the PC-select and flush logic.

---
 rtl/branch_resolve_bht.sv | 186 ++++++++++++++++++
 tb/tb_branch_resolve_bht.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// ID-stage branch/jump resolver with a registered one-cycle redirect, a 2-bit
// saturating branch history table read by IF, and saturating branch statistics.
module branch_resolve_bht #(
    parameter int PC_WIDE    = 7,
    parameter int DATA_WIDTH = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int IDX_W      = 4,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_WIDE-1:0]    fetch_pc,
    output logic                  pred_taken,
    input  logic                  res_valid,
    input  logic                  flush,
    input  logic [5:0]            opcode,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [PC_WIDE-1:0]    res_pc,
    input  logic [PC_WIDE-1:0]    pc_next,
    input  logic [PC_WIDE-1:0]    pc_branch,
    input  logic                  res_pred,
    output logic                  redirect,
    output logic [PC_WIDE-1:0]    redirect_pc,
    output logic                  taken,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     br_count,
    output logic [STAT_W-1:0]     mis_count
);

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [1:0]         bht_r [BHT_DEPTH];
    logic               redirect_r;
    logic [PC_WIDE-1:0] redirect_pc_r;
    logic               taken_r;
    logic [STAT_W-1:0]  br_count_r;
    logic [STAT_W-1:0]  mis_count_r;

    logic               is_cond_s;
    logic               is_jump_s;
    logic               act_s;
    logic               d1_zero_s;
    logic               d1_neg_s;
    logic               live_s;
    logic               cond_go_s;
    logic               jump_go_s;
    logic               mispred_s;
    logic [PC_WIDE-1:0] target_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic [1:0]         bht_cur_s;
    logic [1:0]         bht_nxt_s;
    logic               unused_bits_s;

    assign d1_zero_s = (d1 == {DATA_WIDTH{1'b0}});
    assign d1_neg_s  = d1[DATA_WIDTH-1];
    assign live_s    = res_valid & ~flush;
    assign cond_go_s = live_s & is_cond_s;
    assign jump_go_s = live_s & is_jump_s;
    assign mispred_s = cond_go_s & (act_s != res_pred);
    assign target_s  = pc_next + pc_branch;
    assign upd_idx_s = res_pc[IDX_W-1:0];
    assign bht_cur_s = bht_r[upd_idx_s];

    // Prediction reads the table before any same-cycle update lands.
    assign pred_taken = bht_r[fetch_pc[IDX_W-1:0]][1];

    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign taken       = taken_r;
    assign br_count    = br_count_r;
    assign mis_count   = mis_count_r;

    assign unused_bits_s = ^{fetch_pc, res_pc};

    // Opcode decode and branch condition evaluation.
    always_comb begin
        is_cond_s = 1'b0;
        is_jump_s = 1'b0;
        act_s     = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_cond_s = 1'b1;
                act_s     = (d1 == d2);
            end
            OP_BNE: begin
                is_cond_s = 1'b1;
                act_s     = (d1 != d2);
            end
            OP_BLEZ: begin
                is_cond_s = 1'b1;
                act_s     = d1_neg_s | d1_zero_s;
            end
            OP_BGTZ: begin
                is_cond_s = 1'b1;
                act_s     = ~d1_neg_s & ~d1_zero_s;
            end
            OP_J, OP_JAL: begin
                is_jump_s = 1'b1;
            end
            default: begin
                is_cond_s = 1'b0;
                is_jump_s = 1'b0;
                act_s     = 1'b0;
            end
        endcase
    end

    // Saturating next value for the counter being trained.
    always_comb begin
        bht_nxt_s = bht_cur_s;
        if (act_s) begin
            if (bht_cur_s != 2'b11) begin
                bht_nxt_s = bht_cur_s + 2'b01;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end else begin
            if (bht_cur_s != 2'b00) begin
                bht_nxt_s = bht_cur_s - 2'b01;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end
    end

    // Registered redirect, corrected PC and resolved direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= {PC_WIDE{1'b0}};
            taken_r       <= 1'b0;
        end else if (jump_go_s) begin
            redirect_r    <= 1'b1;
            redirect_pc_r <= pc_branch;
            taken_r       <= 1'b1;
        end else if (cond_go_s) begin
            redirect_r <= mispred_s;
            taken_r    <= act_s;
            if (mispred_s) begin
                redirect_pc_r <= act_s ? target_s : pc_next;
            end
        end else begin
            redirect_r <= 1'b0;
            taken_r    <= 1'b0;
        end
    end

    // Branch history table training on conditional resolutions only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (cond_go_s) begin
            bht_r[upd_idx_s] <= bht_nxt_s;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_r  <= {STAT_W{1'b0}};
            mis_count_r <= {STAT_W{1'b0}};
        end else if (stat_clr) begin
            br_count_r  <= {STAT_W{1'b0}};
            mis_count_r <= {STAT_W{1'b0}};
        end else if (cond_go_s) begin
            if (br_count_r != STAT_MAX) begin
                br_count_r <= br_count_r + STAT_ONE;
            end
            if (mispred_s && (mis_count_r != STAT_MAX)) begin
                mis_count_r <= mis_count_r + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: a driver queues expected outcomes,
// a monitor compares them one cycle later; a narrow-stat copy checks saturation.
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  fetch_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        flush;
    logic [5:0]  opcode;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [6:0]  res_pc;
    logic [6:0]  pc_next;
    logic [6:0]  pc_branch;
    logic        res_pred;
    logic        redirect;
    logic [6:0]  redirect_pc;
    logic        taken;
    logic        stat_clr;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    logic        s_pred;
    logic        s_redirect;
    logic [6:0]  s_redirect_pc;
    logic        s_taken;
    logic [2:0]  s_br;
    logic [2:0]  s_mis;

    typedef struct packed {
        logic [7:0]  id;
        logic        redirect;
        logic [6:0]  rpc;
        logic        taken;
        logic [15:0] br;
        logic [15:0] mis;
        logic [2:0]  sbr;
        logic [2:0]  smis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    branch_resolve_bht dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .flush(flush), .opcode(opcode), .d1(d1), .d2(d2),
        .res_pc(res_pc), .pc_next(pc_next), .pc_branch(pc_branch), .res_pred(res_pred),
        .redirect(redirect), .redirect_pc(redirect_pc), .taken(taken),
        .stat_clr(stat_clr), .br_count(br_count), .mis_count(mis_count)
    );

    branch_resolve_bht #(.STAT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(s_pred),
        .res_valid(res_valid), .flush(flush), .opcode(opcode), .d1(d1), .d2(d2),
        .res_pc(res_pc), .pc_next(pc_next), .pc_branch(pc_branch), .res_pred(res_pred),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .taken(s_taken),
        .stat_clr(stat_clr), .br_count(s_br), .mis_count(s_mis)
    );

    function automatic logic [2:0] sat3(input int x);
        return (x > 7) ? 3'd7 : x[2:0];
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // One stimulus cycle: drive at negedge, check the lookup before the edge, queue the outcome.
    task automatic vec(input logic [7:0] id, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [6:0] rpc_i, input logic [6:0] pn,
                       input logic [6:0] pb, input logic rp, input logic v, input logic fl,
                       input logic clr, input logic [6:0] fpc, input logic pexp,
                       input logic e_r, input logic [6:0] e_pc, input logic e_t,
                       input int e_br, input int e_mis);
        exp_t e;
        @(negedge clk);
        opcode = op; d1 = a; d2 = b; res_pc = rpc_i; pc_next = pn; pc_branch = pb;
        res_pred = rp; res_valid = v; flush = fl; stat_clr = clr; fetch_pc = fpc;
        #1;
        check1($sformatf("pred_vec%0d_pc%0d", id, fpc), {31'd0, pred_taken}, {31'd0, pexp});
        e.id = id; e.redirect = e_r; e.rpc = e_pc; e.taken = e_t;
        e.br = e_br[15:0]; e.mis = e_mis[15:0]; e.sbr = sat3(e_br); e.smis = sat3(e_mis);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each edge against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (redirect === e.redirect && redirect_pc === e.rpc && taken === e.taken &&
                    br_count === e.br && mis_count === e.mis && s_br === e.sbr && s_mis === e.smis)
                    n_pass++;
                else
                    $display("FAIL vec%0d: got r=%b pc=%0d t=%b br=%0d mis=%0d sbr=%0d smis=%0d expected r=%b pc=%0d t=%b br=%0d mis=%0d sbr=%0d smis=%0d",
                             e.id, redirect, redirect_pc, taken, br_count, mis_count, s_br, s_mis,
                             e.redirect, e.rpc, e.taken, e.br, e.mis, e.sbr, e.smis);
            end
        end
    end

    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, BLEZ = 6'b000110, BGTZ = 6'b000111;
    localparam logic [31:0] M1 = 32'hFFFF_FFFF;

    initial begin
        rst_n = 1'b0; fetch_pc = 7'd0; res_valid = 1'b0; flush = 1'b0; opcode = 6'd0;
        d1 = 32'd0; d2 = 32'd0; res_pc = 7'd0; pc_next = 7'd0; pc_branch = 7'd0;
        res_pred = 1'b0; stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        check1("rst_redirect", {31'd0, redirect}, 32'd0);
        check1("rst_redirect_pc", {25'd0, redirect_pc}, 32'd0);
        check1("rst_taken", {31'd0, taken}, 32'd0);
        check1("rst_br", {16'd0, br_count}, 32'd0);
        check1("rst_mis", {16'd0, mis_count}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = i[6:0];
            #1;
            check1($sformatf("rst_pred_%0d", i), {31'd0, pred_taken}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        //   id op    d1  d2  rpc pn   pb   rp v  fl clr fpc pexp  r  pc  t  br mis
        vec(1,  BEQ,  5,  5,  3,  4,   10,  0, 1, 0, 0,  3,  0,    1, 14, 1, 1, 1);
        vec(2,  BEQ,  5,  5,  3,  4,   10,  0, 0, 0, 0,  3,  1,    0, 14, 0, 1, 1);
        vec(3,  BEQ,  5,  5,  3,  4,   10,  1, 1, 0, 0,  3,  1,    0, 14, 1, 2, 1);
        vec(4,  BEQ,  5,  5,  3,  4,   10,  1, 1, 0, 0,  3,  1,    0, 14, 1, 3, 1);
        vec(5,  BEQ,  5,  5,  3,  4,   10,  1, 1, 0, 0,  3,  1,    0, 14, 1, 4, 1);
        vec(6,  BEQ,  5,  6,  3,  4,   10,  1, 1, 0, 0,  3,  1,    1, 4,  0, 5, 2);
        vec(7,  BEQ,  5,  6,  3,  4,   10,  1, 1, 0, 0,  3,  1,    1, 4,  0, 6, 3);
        vec(8,  BLEZ, M1, 0,  8,  120, 10,  0, 1, 0, 0,  3,  0,    1, 2,  1, 7, 4);
        vec(9,  BGTZ, 0,  0,  9,  20,  5,   0, 1, 0, 0,  8,  1,    0, 2,  0, 8, 4);
        vec(10, BGTZ, 1,  0,  10, 30,  3,   0, 1, 0, 0,  9,  0,    1, 33, 1, 9, 5);
        vec(11, BLEZ, 1,  0,  11, 40,  3,   0, 1, 0, 0,  10, 1,    0, 33, 0, 10, 5);
        vec(12, BNE,  1,  2,  12, 50,  100, 1, 1, 0, 0,  11, 0,    0, 33, 1, 11, 5);
        vec(13, BNE,  7,  7,  13, 60,  5,   1, 1, 0, 0,  12, 1,    1, 60, 0, 12, 6);
        vec(14, J,    0,  0,  3,  4,   77,  0, 1, 0, 0,  13, 0,    1, 77, 1, 12, 6);
        vec(15, J,    0,  0,  3,  4,   50,  0, 1, 1, 0,  3,  0,    0, 77, 0, 12, 6);
        vec(16, JAL,  0,  0,  4,  5,   99,  0, 1, 0, 0,  3,  0,    1, 99, 1, 12, 6);
        vec(17, BEQ,  9,  9,  5,  1,   1,   0, 1, 1, 0,  3,  0,    0, 99, 0, 12, 6);
        vec(18, 6'd0, 9,  9,  5,  1,   1,   0, 1, 0, 0,  3,  0,    0, 99, 0, 12, 6);
        vec(19, BEQ,  9,  9,  5,  6,   2,   0, 1, 0, 0,  5,  0,    1, 8,  1, 13, 7);
        vec(20, BEQ,  9,  9,  5,  6,   2,   0, 0, 0, 0,  5,  1,    0, 8,  0, 13, 7);
        vec(21, BEQ,  9,  9,  6,  1,   1,   0, 1, 0, 1,  5,  1,    1, 2,  1, 0, 0);
        vec(22, BEQ,  9,  9,  6,  1,   1,   0, 0, 0, 0,  6,  1,    0, 2,  0, 0, 0);
        vec(23, BEQ,  5,  5,  3,  4,   10,  0, 1, 0, 0,  3,  0,    1, 14, 1, 1, 1);

        // Reset while the redirect from vec 23 is on the outputs.
        @(posedge clk);
        #2;
        res_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check1("midrst_redirect", {31'd0, redirect}, 32'd0);
        check1("midrst_redirect_pc", {25'd0, redirect_pc}, 32'd0);
        check1("midrst_taken", {31'd0, taken}, 32'd0);
        check1("midrst_br", {16'd0, br_count}, 32'd0);
        check1("midrst_mis", {16'd0, mis_count}, 32'd0);
        fetch_pc = 7'd5;
        #1;
        check1("midrst_pred5", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
